// File: rtl/fetch_pkg.sv
// Shared types for the instruction-fetch controller: FSM states, instruction
// size and the fetch-buffer entry layout.
package fetch_pkg;

  typedef enum logic [1:0] {
    S_RST   = 2'd0,
    S_FETCH = 2'd1,
    S_FAULT = 2'd2
  } fetch_state_e;

  localparam int unsigned INSTR_BYTES = 4;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_buf.sv
// Two-entry FIFO holding fetched {pc, instr} pairs for decode. Entry 0 is
// always the head; flush empties the buffer and overrides push and pop.
module fetch_buf
  import fetch_pkg::*;
(
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         push_i,
  input  fetch_entry_t push_data_i,
  input  logic         pop_i,
  input  logic         flush_i,
  output logic [1:0]   count_o,
  output fetch_entry_t head_o
);

  logic [1:0]   count_q, count_d;
  fetch_entry_t ent0_q, ent0_d;
  fetch_entry_t ent1_q, ent1_d;
  logic         do_pop, do_push;

  // Pops need a head; pushes need a free slot, or one freed by a same-cycle pop.
  assign do_pop  = pop_i & (count_q != 2'd0);
  assign do_push = push_i & ((count_q != 2'd2) | do_pop);

  // Next occupancy and entry contents; entry 0 stays the head after a pop.
  always_comb begin
    count_d = count_q;
    ent0_d  = ent0_q;
    ent1_d  = ent1_q;
    if (flush_i) begin
      count_d = 2'd0;
    end else if (do_pop && do_push) begin
      if (count_q == 2'd2) begin
        ent0_d = ent1_q;
        ent1_d = push_data_i;
      end else begin
        ent0_d = push_data_i;
      end
    end else if (do_pop) begin
      ent0_d  = ent1_q;
      count_d = count_q - 2'd1;
    end else if (do_push) begin
      if (count_q == 2'd0) begin
        ent0_d = push_data_i;
      end else begin
        ent1_d = push_data_i;
      end
      count_d = count_q + 2'd1;
    end
  end

  // Occupancy is the only state that must clear on reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q <= 2'd0;
    end else begin
      count_q <= count_d;
    end
  end

  // Entry payloads are qualified by count, so they carry no reset.
  always_ff @(posedge clk_i) begin
    ent0_q <= ent0_d;
    ent1_q <= ent1_d;
  end

  assign count_o = count_q;
  assign head_o  = (count_q != 2'd0) ? ent0_q : '0;

endmodule

// File: rtl/instr_fetch_ctrl.sv
// Instruction-fetch controller: owns the PC, sequences the instruction memory,
// checks fetch legality and feeds decode through a 2-entry fetch buffer.
module instr_fetch_ctrl
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] MEM_BYTES = 32'h0000_0100
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  output logic [31:0] o_imem_adr,
  input  logic [31:0] i_imem_instr,
  output logic        o_imem_rst,
  output logic        o_if_valid,
  output logic [31:0] o_if_instr,
  output logic [31:0] o_if_pc,
  input  logic        i_id_ready,
  input  logic        i_redirect,
  input  logic [31:0] i_redirect_pc,
  output logic        o_fault
);

  localparam logic [31:0] LAST_ADR = MEM_BYTES - 32'(INSTR_BYTES);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [1:0]   count;
  fetch_entry_t head, push_data;
  logic         pop, push, flush, pc_legal;

  assign pop       = o_if_valid & i_id_ready;
  assign pc_legal  = (pc_q[1:0] == 2'b00) & (pc_q <= LAST_ADR);
  assign push_data = '{pc: pc_q, instr: i_imem_instr};

  // Next state, PC and buffer controls; a redirect outranks fetch and fault.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    push       = 1'b0;
    flush      = 1'b0;
    o_imem_rst = 1'b0;
    unique case (state_q)
      S_RST: begin
        o_imem_rst = 1'b1;
        state_d    = S_FETCH;
      end
      S_FETCH: begin
        if (i_redirect) begin
          flush = 1'b1;
          pc_d  = i_redirect_pc;
        end else if (!pc_legal) begin
          state_d = S_FAULT;
        end else if ((count != 2'd2) || pop) begin
          push = 1'b1;
          pc_d = pc_q + 32'(INSTR_BYTES);
        end
      end
      S_FAULT: begin
        state_d = S_FAULT;
      end
      default: begin
        o_imem_rst = 1'b1;
        state_d    = S_RST;
      end
    endcase
  end

  // State and PC registers, cleared asynchronously.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= S_RST;
      pc_q    <= RESET_PC;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  fetch_buf u_buf (
    .clk_i       (i_clk),
    .rst_ni      (i_rst_n),
    .push_i      (push),
    .push_data_i (push_data),
    .pop_i       (pop),
    .flush_i     (flush),
    .count_o     (count),
    .head_o      (head)
  );

  assign o_imem_adr = pc_q;
  assign o_if_valid = (count != 2'd0);
  assign o_if_instr = head.instr;
  assign o_if_pc    = head.pc;
  assign o_fault    = (state_q == S_FAULT);

endmodule

// File: tb/tb_instr_fetch_ctrl.sv
// Randomised scoreboard bench for instr_fetch_ctrl. A queue-based model of the
// fetch rules predicts per-cycle status and the instruction stream delivered
// to decode; a negedge monitor pops and compares.
module tb_instr_fetch_ctrl;

  localparam logic [31:0] MEMB = 32'h0000_0100;
  localparam logic [31:0] LAST = MEMB - 32'd4;

  typedef struct {
    bit          valid;
    bit          fault;
    bit          rst;
    bit          chk_adr;
    logic [31:0] adr;
    bit          accept;
  } st_t;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } ent_t;

  logic        clk;
  logic        rst_n;
  logic [31:0] imem_adr;
  logic [31:0] imem_instr;
  logic        imem_rst;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic        id_ready;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        fault;

  logic [31:0] mem [64];

  st_t  st_q  [$];
  ent_t exp_q [$];
  ent_t m_buf [$];
  int          m_state;  // 0 reset, 1 fetching, 2 faulted
  logic [31:0] m_pc;

  int tests = 0;
  int fails = 0;

  instr_fetch_ctrl dut (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .o_imem_adr    (imem_adr),
    .i_imem_instr  (imem_instr),
    .o_imem_rst    (imem_rst),
    .o_if_valid    (if_valid),
    .o_if_instr    (if_instr),
    .o_if_pc       (if_pc),
    .i_id_ready    (id_ready),
    .i_redirect    (redirect),
    .i_redirect_pc (redirect_pc),
    .o_fault       (fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Combinational instruction memory; out-of-range reads return a marker.
  always_comb begin
    imem_instr = 32'hDEAD_BEEF;
    if (imem_adr < MEMB) imem_instr = mem[imem_adr[7:2]];
  end

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", n, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_state = 0;
    m_pc    = 32'h0;
    m_buf.delete();
  endtask

  // One clock of stimulus; the model predicts what the DUT shows this cycle
  // and how it advances at the next rising edge.
  task automatic cycle(input bit rdy, input bit rd, input logic [31:0] rpc, input bit rstp);
    st_t  s;
    ent_t e;
    bit   pop;
    @(posedge clk);
    #1;
    if (rstp) begin
      rst_n = 1'b0;
      model_reset();
    end
    id_ready    = rdy;
    redirect    = rd;
    redirect_pc = rpc;
    s.valid   = (m_buf.size() != 0);
    s.fault   = (m_state == 2);
    s.rst     = (m_state == 0);
    s.chk_adr = (m_state == 1);
    s.adr     = m_pc;
    s.accept  = 1'b0;
    pop = s.valid && rdy;
    if (m_state == 0) begin
      m_state = 1;
    end else if (m_state == 1) begin
      if (rd) begin
        m_buf.delete();
        m_pc = rpc;
      end else begin
        if (pop) begin
          s.accept = 1'b1;
          exp_q.push_back(m_buf.pop_front());
        end
        if ((m_pc % 4) != 0 || m_pc > LAST) begin
          m_state = 2;
        end else if (m_buf.size() < 2) begin
          e.pc    = m_pc;
          e.instr = mem[m_pc / 4];
          m_buf.push_back(e);
          m_pc = m_pc + 4;
        end
      end
    end else if (pop) begin
      s.accept = 1'b1;
      exp_q.push_back(m_buf.pop_front());
    end
    st_q.push_back(s);
    if (rstp) begin
      #1;
      chk("rst_pulse_valid", {31'b0, if_valid}, 32'd0);
      chk("rst_pulse_imem_rst", {31'b0, imem_rst}, 32'd1);
      chk("rst_pulse_fault", {31'b0, fault}, 32'd0);
      #4;
      rst_n = 1'b1;
    end
  endtask

  st_t  ms;
  ent_t me;

  // Scoreboard monitor: compare the DUT against the predicted status each cycle.
  always @(negedge clk) begin
    if (st_q.size() != 0) begin
      ms = st_q.pop_front();
      chk("if_valid", {31'b0, if_valid}, {31'b0, ms.valid});
      chk("fault", {31'b0, fault}, {31'b0, ms.fault});
      chk("imem_rst", {31'b0, imem_rst}, {31'b0, ms.rst});
      if (ms.chk_adr) chk("imem_adr", imem_adr, ms.adr);
      if (!ms.valid) begin
        chk("empty_pc", if_pc, 32'd0);
        chk("empty_instr", if_instr, 32'd0);
      end
      if (ms.accept) begin
        if (exp_q.size() == 0) begin
          chk("exp_underflow", 32'd1, 32'd0);
        end else begin
          me = exp_q.pop_front();
          chk("if_pc", if_pc, me.pc);
          chk("if_instr", if_instr, me.instr);
        end
      end
    end
  end

  initial begin
    logic [31:0] t;
    for (int i = 0; i < 64; i++) mem[i] = $urandom;
    rst_n       = 1'b0;
    id_ready    = 1'b0;
    redirect    = 1'b0;
    redirect_pc = 32'h0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("reset_valid", {31'b0, if_valid}, 32'd0);
    chk("reset_imem_rst", {31'b0, imem_rst}, 32'd1);
    chk("reset_fault", {31'b0, fault}, 32'd0);
    chk("reset_pc", if_pc, 32'd0);
    chk("reset_instr", if_instr, 32'd0);

    // Release from reset, then stream with decode always ready.
    cycle(1'b1, 1'b0, 32'h0, 1'b1);
    repeat (15) cycle(1'b1, 1'b0, 32'h0, 1'b0);
    // Decode stalls, buffer fills, then drains in order.
    repeat (5) cycle(1'b0, 1'b0, 32'h0, 1'b0);
    repeat (10) cycle(1'b1, 1'b0, 32'h0, 1'b0);
    // Redirect with a full buffer.
    repeat (3) cycle(1'b0, 1'b0, 32'h0, 1'b0);
    cycle(1'b1, 1'b1, 32'h30, 1'b0);
    repeat (8) cycle(1'b1, 1'b0, 32'h0, 1'b0);
    // Random traffic with aligned, in-range redirects.
    repeat (200) begin
      t = 32'($urandom_range(0, 63)) * 4;
      cycle(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 9) == 0), t, 1'b0);
    end
    // Run off the end of memory: 0xFC delivered, then fault and drain.
    cycle(1'b1, 1'b1, 32'hE0, 1'b0);
    repeat (20) cycle(1'b1, 1'b0, 32'h0, 1'b0);
    // Half-cycle reset pulse clears the fault and restarts at the reset PC.
    cycle(1'b1, 1'b0, 32'h0, 1'b1);
    repeat (10) cycle(1'b1, 1'b0, 32'h0, 1'b0);
    // Misaligned redirect faults; a later legal redirect is ignored.
    cycle(1'b1, 1'b1, 32'h62, 1'b0);
    repeat (5) cycle(1'b1, 1'b0, 32'h0, 1'b0);
    cycle(1'b1, 1'b1, 32'h60, 1'b0);
    repeat (5) cycle(1'b1, 1'b0, 32'h0, 1'b0);
    cycle(1'b0, 1'b0, 32'h0, 1'b1);
    repeat (10) cycle(1'b1, 1'b0, 32'h0, 1'b0);
    // Random traffic with occasional illegal targets and mid-stream resets.
    repeat (3) begin
      repeat (150) begin
        if ($urandom_range(0, 4) == 0) t = 32'($urandom_range(0, 32'h110));
        else t = 32'($urandom_range(0, 63)) * 4;
        cycle(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 11) == 0), t, 1'b0);
      end
      cycle(1'($urandom_range(0, 1)), 1'b0, 32'h0, 1'b1);
    end
    repeat (20) cycle(1'b1, 1'b0, 32'h0, 1'b0);

    #5;
    chk("status_queue_drained", 32'(st_q.size()), 32'd0);
    chk("data_queue_drained", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
